// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared states, command codes and oversampling constant for the UART command receiver
//
// Purpose: common definitions imported by baud_tick_gen and uart_cmd_rx.
// Ports:   none (package).
package uart_pkg;

  localparam int OVERSAMPLE = 16;

  localparam logic [7:0] CMD_LEFT  = 8'd108;
  localparam logic [7:0] CMD_RIGHT = 8'd114;
  localparam logic [7:0] CMD_HOLD  = 8'd100;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_t;

  // Anything that is not a recognised paddle command is treated as "hold".
  function automatic logic [7:0] cmd_filter(input logic [7:0] b);
    if (b == CMD_LEFT || b == CMD_RIGHT || b == CMD_HOLD) begin
      return b;
    end
    return CMD_HOLD;
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// rtl/baud_tick_gen.sv - free-running 16x oversampling tick divider
//
// Purpose: pulses tick for one clk every CLK_FREQ/(BAUD*OVERSAMPLE) clocks.
// Ports:
//   clk   - system clock, rising edge
//   rst_n - synchronous active-low reset
//   tick  - one-clk oversampling strobe
module baud_tick_gen #(
  parameter int CLK_FREQ = 100000000,
  parameter int BAUD     = 9600
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);
  import uart_pkg::*;

  localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick = (cnt_q == CW'(DIV - 1));

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_cmd_rx.sv
// rtl/uart_cmd_rx.sv - 8N1 UART receiver that turns framed bytes into paddle commands
//
// Purpose: receives 8N1 frames on rx, reports each good byte and stop-bit errors,
//          and presents a paddle command on rxdata that defaults to CMD_HOLD.
// Ports:
//   clk       - system clock, rising edge
//   rst_n     - synchronous active-low reset
//   rx        - asynchronous serial line, idle high
//   rxdata    - paddle command, CMD_HOLD except on the rx_valid clk
//   rx_byte   - last correctly framed byte
//   rx_valid  - one-clk pulse, rx_byte updated
//   frame_err - one-clk pulse, stop bit sampled low
module uart_cmd_rx #(
  parameter int CLK_FREQ = 100000000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rxdata,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_err
);
  import uart_pkg::*;

  localparam logic [3:0] MID_TICK  = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);

  logic       tick;
  logic [1:0] sync_q;
  logic       rx_s;

  rx_state_t  state_q, state_d;
  logic [3:0] tick_cnt_q, tick_cnt_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] rx_byte_q, rx_byte_d;
  logic [7:0] rxdata_q, rxdata_d;
  logic       rx_valid_q, rx_valid_d;
  logic       frame_err_q, frame_err_d;

  baud_tick_gen #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD    (BAUD)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  // Resets to 11 so a reset release does not look like a start edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rx};
    end
  end

  assign rx_s = sync_q[1];

  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    rx_byte_d   = rx_byte_q;
    rxdata_d    = CMD_HOLD;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d    = START;
          tick_cnt_d = '0;
        end
      end
      START: begin
        // Mid start bit: a line back high here was only a glitch.
        if (tick) begin
          if (tick_cnt_q == MID_TICK) begin
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
            state_d    = rx_s ? IDLE : DATA;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (tick_cnt_q == LAST_TICK) begin
            tick_cnt_d = '0;
            shift_d    = {rx_s, shift_q[7:1]};
            bit_cnt_d  = bit_cnt_q + 1'b1;
            if (bit_cnt_q == 3'd7) begin
              state_d = STOP;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (tick_cnt_q == LAST_TICK) begin
            tick_cnt_d = '0;
            if (rx_s) begin
              state_d    = IDLE;
              rx_byte_d  = shift_q;
              rx_valid_d = 1'b1;
              rxdata_d   = cmd_filter(shift_q);
            end else begin
              state_d     = WAIT_HIGH;
              frame_err_d = 1'b1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end
      WAIT_HIGH: begin
        // Hold off through a break so it cannot masquerade as a start bit.
        if (rx_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      tick_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rx_byte_q   <= '0;
      rxdata_q    <= CMD_HOLD;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rx_byte_q   <= rx_byte_d;
      rxdata_q    <= rxdata_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign rxdata    = rxdata_q;
  assign rx_byte   = rx_byte_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// tb/tb_uart_cmd_rx.sv - self-checking bench for uart_cmd_rx
module tb_uart_cmd_rx;
  import uart_pkg::*;

  // Scaled clock/baud so whole frames fit in a short run: DIV = 5, 80 clk per bit.
  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 12_500;
  localparam int DIV      = CLK_FREQ / (BAUD * 16);
  localparam int BITC     = DIV * 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] rxdata;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       frame_err;

  always #5 clk = ~clk;

  uart_cmd_rx #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD    (BAUD)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx       (rx),
    .rxdata   (rxdata),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .frame_err(frame_err)
  );

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         hold;
    int         exp_valid;
    int         exp_ferr;
    logic [7:0] exp_byte;
    logic [7:0] exp_cmd;
  } vec_t;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int n_valid = 0;
  int n_ferr = 0;
  int n_bad = 0;
  logic [7:0] got_c[$];
  int         got_t[$];

  // Monitor samples 1 time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    if (rx_valid) begin
      n_valid = n_valid + 1;
      got_c.push_back(rxdata);
      got_t.push_back(cyc);
    end
    if (frame_err) n_ferr = n_ferr + 1;
    if (!rx_valid && rxdata !== 8'd100) n_bad = n_bad + 1;
    if (rx_valid && frame_err) n_bad = n_bad + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got no finish required finish");
    $fatal(1);
  end

  function automatic logic [7:0] model_cmd(input logic [7:0] b);
    return (b == 8'd108 || b == 8'd114 || b == 8'd100) ? b : 8'd100;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int hold_low);
    drive(1'b0, BITC);
    for (int i = 0; i < 8; i++) drive(d[i], BITC);
    drive(stop, BITC);
    if (!stop) drive(1'b0, hold_low);
    rx = 1'b1;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int v0, f0, b0;
    v0 = n_valid; f0 = n_ferr; b0 = n_bad;
    got_c.delete();
    send_frame(v.data, v.stop, v.hold);
    drive(1'b1, BITC);
    check({tag, "_valid"}, n_valid - v0, v.exp_valid);
    check({tag, "_ferr"}, n_ferr - f0, v.exp_ferr);
    check({tag, "_hold_rule"}, n_bad - b0, 0);
    check({tag, "_rx_byte"}, int'(rx_byte), int'(v.exp_byte));
    if (v.exp_valid == 1 && got_c.size() > 0)
      check({tag, "_rxdata"}, int'(got_c[got_c.size()-1]), int'(v.exp_cmd));
  endtask

  vec_t vecs[8];
  vec_t rv;
  logic [7:0] last_good;
  logic [7:0] d;
  int v0, f0, dt;

  initial begin
    vecs[0] = '{8'h6C, 1'b1, 0,    1, 0, 8'h6C, 8'd108};
    vecs[1] = '{8'h72, 1'b1, 0,    1, 0, 8'h72, 8'd114};
    vecs[2] = '{8'h64, 1'b1, 0,    1, 0, 8'h64, 8'd100};
    vecs[3] = '{8'h41, 1'b1, 0,    1, 0, 8'h41, 8'd100};
    vecs[4] = '{8'h00, 1'b1, 0,    1, 0, 8'h00, 8'd100};
    vecs[5] = '{8'hFF, 1'b1, 0,    1, 0, 8'hFF, 8'd100};
    vecs[6] = '{8'h72, 1'b0, 2000, 0, 1, 8'hFF, 8'd100};
    vecs[7] = '{8'h6C, 1'b1, 0,    1, 0, 8'h6C, 8'd108};

    // Reset values
    rst_n = 1'b0; rx = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_rxdata", int'(rxdata), 100);
    check("rst_rx_byte", int'(rx_byte), 0);
    check("rst_valid", int'(rx_valid), 0);
    check("rst_ferr", int'(frame_err), 0);
    check("rst_state", int'(dut.state_q), int'(IDLE));
    rst_n = 1'b1;
    drive(1'b1, 20);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back 'r' then 'd'
    v0 = n_valid;
    got_c.delete(); got_t.delete();
    send_frame(8'h72, 1'b1, 0);
    send_frame(8'h64, 1'b1, 0);
    drive(1'b1, BITC);
    check("b2b_valid", n_valid - v0, 2);
    if (got_c.size() == 2) begin
      check("b2b_cmd0", int'(got_c[0]), 114);
      check("b2b_cmd1", int'(got_c[1]), 100);
      dt = got_t[1] - got_t[0];
      check("b2b_spacing_ok", (dt >= 10*BITC - DIV - 2 && dt <= 10*BITC + DIV + 2) ? 1 : 0, 1);
    end

    // Short low glitch is rejected at the start-bit midpoint
    v0 = n_valid; f0 = n_ferr;
    drive(1'b0, 25);
    drive(1'b1, BITC);
    check("glitch_valid", n_valid - v0, 0);
    check("glitch_ferr", n_ferr - f0, 0);
    check("glitch_state", int'(dut.state_q), int'(IDLE));
    run_vec(vecs[0], "post_glitch");

    // Reset in the middle of data bit 4 of 'r' (bit 4 is high, line stays idle)
    v0 = n_valid; f0 = n_ferr;
    drive(1'b0, BITC);
    for (int i = 0; i < 4; i++) drive(vecs[1].data[i], BITC);
    drive(vecs[1].data[4], BITC / 2);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_rxdata", int'(rxdata), 100);
    check("midrst_rx_byte", int'(rx_byte), 0);
    check("midrst_valid", int'(rx_valid), 0);
    check("midrst_ferr", int'(frame_err), 0);
    rst_n = 1'b1;
    drive(1'b1, 12 * BITC);
    check("midrst_no_pulse", (n_valid - v0) + (n_ferr - f0), 0);
    run_vec(vecs[1], "post_rst");

    // Randomized frames against the reference model
    last_good = 8'h72;
    for (int i = 0; i < 25; i++) begin
      case ($urandom_range(0, 5))
        0: d = 8'd108;
        1: d = 8'd114;
        2: d = 8'd100;
        default: d = 8'($urandom_range(0, 255));
      endcase
      rv.data = d;
      rv.stop = ($urandom_range(0, 7) != 0);
      rv.hold = rv.stop ? 0 : int'($urandom_range(BITC, 3 * BITC));
      rv.exp_valid = rv.stop ? 1 : 0;
      rv.exp_ferr  = rv.stop ? 0 : 1;
      if (rv.stop) last_good = d;
      rv.exp_byte = last_good;
      rv.exp_cmd  = model_cmd(d);
      drive(1'b1, int'($urandom_range(0, 30)));
      run_vec(rv, $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_cmd_rx.md
UART_CMD_RX -- requirements
Module: uart_cmd_rx

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 100000000, meaning system clock frequency in Hz.
REQ-002 The block SHALL have parameter BAUD, default 9600, meaning serial bit rate.
REQ-003 The block SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 The block SHALL have port rx  input  1  asynchronous UART serial line, idle high.
REQ-006 The block SHALL have port rxdata  output  8  paddle command byte, consumed every clk by the paddle controller.
REQ-007 The block SHALL have port rx_byte  output  8  last correctly framed raw byte.
REQ-008 The block SHALL have port rx_valid  output  1  one-cycle pulse, rx_byte updated.
REQ-009 The block SHALL have port frame_err  output  1  one-cycle pulse, stop bit sampled low.

Function
REQ-010 rx SHALL pass a 2-flop synchronizer before any use; all timing below counts from the synchronized signal.
REQ-011 A tick SHALL be generated every DIV = CLK_FREQ/(BAUD*16) clocks (integer truncation; 651 at defaults); the divider SHALL free-run.
REQ-012 The FSM SHALL have states IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-013 IDLE -> START on synchronized rx low; the tick counter SHALL clear on entry.
REQ-014 START: at tick 8, rx low -> DATA; rx high -> IDLE (glitch rejected, no pulse).
REQ-015 DATA: sample at every 16th tick after the start-bit midpoint; LSB first; 8 bits; then -> STOP.
REQ-016 STOP: at 16th tick, rx high -> IDLE with rx_byte <= shift register and rx_valid = 1 the next clk.
REQ-017 STOP: at 16th tick, rx low -> WAIT_HIGH, frame_err = 1 for one clk, rx_byte unchanged, no rx_valid.
REQ-018 WAIT_HIGH -> IDLE only when synchronized rx is high (break conditions never start a new frame).
REQ-019 rxdata SHALL equal CMD_HOLD (100) except for exactly the clk coinciding with rx_valid.
REQ-020 On that clk, rxdata SHALL equal rx_byte if it is CMD_LEFT (108), CMD_RIGHT (114) or CMD_HOLD (100); otherwise CMD_HOLD.
REQ-021 rx_valid and frame_err SHALL never be high in the same cycle; each is high for exactly one clk per frame.
REQ-022 Latency: rx_valid SHALL rise 1 clk after the stop-bit mid-sample tick.

Reset
REQ-023 While rst_n is low at a clk edge: state = IDLE, counters = 0, synchronizer = 11, rxdata = 100, rx_byte = 0, rx_valid = 0, frame_err = 0.
REQ-024 Reset asserted mid-frame SHALL abort the frame with no pulse; the next falling edge after reset release starts a new frame.

Structure
REQ-025 State enumeration, CMD_LEFT/CMD_RIGHT/CMD_HOLD and OVERSAMPLE = 16 SHALL live in shared package uart_pkg.
REQ-026 The tick divider SHALL be a separate sub-module, baud_tick_gen (parameters CLK_FREQ, BAUD; ports clk, rst_n, tick).

Verification
REQ-027 Frame 0x6C ('l') at 9600 baud (10416 clk/bit) -> one rx_valid, rx_byte = 0x6C, rxdata = 108 for exactly 1 clk, then 100.
REQ-028 Frames 'r' then 'd' back-to-back -> rxdata pulses 114, then 100; two rx_valid pulses spaced about 104160 clk.
REQ-029 Frame 0x41 ('A') -> rx_valid = 1, rx_byte = 0x41, rxdata stays 100 throughout.
REQ-030 rx low for 3000 clk then high -> no rx_valid, no frame_err, FSM returns to IDLE.
REQ-031 Frame 0x72 with stop bit low, line held low 20000 clk -> one frame_err, no rx_valid; next clean 'l' is received correctly.
REQ-032 rst_n low for 2 clk during data bit 4 of a frame -> outputs at reset values, no pulse; the following 'r' frame yields rxdata = 114.
